wptr_full_ctrl: RTL

Write-side pointer and status controller for the asynchronous FIFO, parametrised in depth, and a successor to the basic write-pointer handler. It keeps binary and Gray write pointers and emits the RAM write address and write strobe. It derives full, almost_full, fill level and a sticky overflow error from an already-synchronised Gray read pointer. All flags are computed from the next-state pointer, so full asserts on the same edge as the write that fills the FIFO.

---
 rtl/wptr_full_ctrl_if.sv | 39 +++
 rtl/wptr_full_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/wptr_full_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : wptr_full_ctrl_if
// Description : Write-side pointer/status bundle of the asynchronous FIFO.
//               Groups the write request, the synchronised Gray read pointer,
//               the status thresholds and every pointer/flag output.
//   master : write client (drives w_en, g_rptr_sync, afull_thresh, clr_ovf)
//   slave  : wptr_full_ctrl (drives waddr, w_accept, pointers and flags)
// Revision    : 1.0 - initial release
// ============================================================================
interface wptr_full_ctrl_if #(
  parameter int PTRWIDTH = 3
);
  // Client side
  logic                w_en;
  logic [PTRWIDTH:0]   g_rptr_sync;
  logic [PTRWIDTH:0]   afull_thresh;
  logic                clr_ovf;
  // Controller side
  logic [PTRWIDTH-1:0] waddr;
  logic                w_accept;
  logic [PTRWIDTH:0]   b_wptr;
  logic [PTRWIDTH:0]   g_wptr;
  logic                full;
  logic                almost_full;
  logic [PTRWIDTH:0]   wlevel;
  logic                overflow;

  modport master (
    output w_en, g_rptr_sync, afull_thresh, clr_ovf,
    input  waddr, w_accept, b_wptr, g_wptr, full, almost_full, wlevel, overflow
  );

  modport slave (
    input  w_en, g_rptr_sync, afull_thresh, clr_ovf,
    output waddr, w_accept, b_wptr, g_wptr, full, almost_full, wlevel, overflow
  );
endinterface
`default_nettype wire

// File: rtl/wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wptr_full_ctrl
// Description : Write-side pointer and status controller of the asynchronous
//               FIFO. Keeps binary and Gray write pointers, drives the RAM
//               write address/strobe and derives full, almost_full, fill level
//               and a sticky overflow flag from the synchronised Gray read
//               pointer. Every flag is computed from the next-state pointer,
//               so full rises on the same edge as the write that fills.
// Ports       :
//   wclk  - write-domain clock, all state changes on its rising edge
//   wrst  - asynchronous active-high reset, clears all registered outputs
//   bus   - wptr_full_ctrl_if.slave:
//             w_en, g_rptr_sync, afull_thresh, clr_ovf           (inputs)
//             waddr, w_accept, b_wptr, g_wptr, full, almost_full,
//             wlevel, overflow                                   (outputs)
// Parameters  : PTRWIDTH - address bits, depth 2**PTRWIDTH, legal 2..12
// Revision    : 1.0 - initial release
// ============================================================================
module wptr_full_ctrl #(
  parameter int PTRWIDTH = 3
) (
  input  wire logic       wclk,
  input  wire logic       wrst,
  wptr_full_ctrl_if.slave bus
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PTRWIDTH:0] r_b_wptr;
  logic [PTRWIDTH:0] r_g_wptr;
  logic [PTRWIDTH:0] r_wlevel;
  logic              r_full;
  logic              r_almost_full;
  logic              r_overflow;

  // --------------------------------------------------------------------------
  // Next-state wires
  // --------------------------------------------------------------------------
  logic [PTRWIDTH:0] w_rbin;
  logic [PTRWIDTH:0] w_b_next;
  logic [PTRWIDTH:0] w_g_next;
  logic [PTRWIDTH:0] w_level_next;
  logic [PTRWIDTH:0] w_full_pattern;
  logic              w_accept;
  logic              w_full_next;
  logic              w_afull_next;
  logic              w_ovf_next;

  // --------------------------------------------------------------------------
  // Gray-to-binary of the read pointer. Bit i of the binary value is the XOR
  // of all Gray bits from the MSB down to i; writing each bit as a reduction
  // of the shifted Gray word keeps the chain free of bit-level feedback.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i <= PTRWIDTH; i++) begin : g_g2b
      assign w_rbin[i] = ^(bus.g_rptr_sync >> i);
    end
  endgenerate

  // A write is only taken while the registered full flag is low.
  assign w_accept = bus.w_en & ~r_full;

  assign w_b_next = r_b_wptr + {{PTRWIDTH{1'b0}}, w_accept};
  assign w_g_next = w_b_next ^ (w_b_next >> 1);

  // In Gray code the write pointer is exactly one lap ahead of the read
  // pointer when the two MSBs are inverted and the remaining bits match.
  assign w_full_pattern = {~bus.g_rptr_sync[PTRWIDTH:PTRWIDTH-1],
                           bus.g_rptr_sync[PTRWIDTH-2:0]};
  assign w_full_next    = (w_g_next == w_full_pattern);

  // Modular difference; the extra pointer bit lets it reach DEPTH.
  assign w_level_next = w_b_next - w_rbin;
  assign w_afull_next = (w_level_next >= bus.afull_thresh);

  // A dropped write sets the sticky flag and wins over a same-edge clear.
  always_comb begin
    w_ovf_next = r_overflow;
    if (bus.w_en && r_full) begin
      w_ovf_next = 1'b1;
    end else if (bus.clr_ovf) begin
      w_ovf_next = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_b_wptr      <= '0;
      r_g_wptr      <= '0;
      r_wlevel      <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_b_wptr      <= w_b_next;
      r_g_wptr      <= w_g_next;
      r_wlevel      <= w_level_next;
      r_full        <= w_full_next;
      r_almost_full <= w_afull_next;
      r_overflow    <= w_ovf_next;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Only the registered Gray pointer leaves this domain.
  // --------------------------------------------------------------------------
  assign bus.waddr       = r_b_wptr[PTRWIDTH-1:0];
  assign bus.w_accept    = w_accept;
  assign bus.b_wptr      = r_b_wptr;
  assign bus.g_wptr      = r_g_wptr;
  assign bus.full        = r_full;
  assign bus.almost_full = r_almost_full;
  assign bus.wlevel      = r_wlevel;
  assign bus.overflow    = r_overflow;

endmodule
`default_nettype wire
